// File: rtl/boreal_ledger_pkg.sv
// Shared definitions for the boreal ledger ring: MMIO register offsets,
// CTRL/STATUS bit positions and the MMIO FSM state encoding.
package boreal_ledger_pkg;

    localparam logic [7:0] OFF_IDX     = 8'h00;
    localparam logic [7:0] OFF_DEPTH   = 8'h04;
    localparam logic [7:0] OFF_CTRL    = 8'h08;
    localparam logic [7:0] OFF_STATUS  = 8'h0C;
    localparam logic [7:0] OFF_RD_ADDR = 8'h10;
    localparam logic [7:0] OFF_RD_WORD = 8'h14;
    localparam logic [7:0] OFF_RD_DATA = 8'h18;
    localparam logic [7:0] OFF_COUNT   = 8'h1C;

    localparam int CTRL_WRAP_EN = 0;
    localparam int CTRL_SEAL    = 1;

    localparam int STAT_FULL     = 0;
    localparam int STAT_OVERFLOW = 1;
    localparam int STAT_SEALED   = 2;
    localparam int STAT_WRAPPED  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_ACK  = 2'd2
    } mmio_state_e;

endpackage

// File: rtl/boreal_ledger_ring_if.sv
// Bus bundle for the ledger ring: the Gate commit handshake (wr_valid/
// wr_ready/wr_data plus idx/full status) and the MMIO register port
// (sel/wr/addr/wdata in, rdata/ack out).
//   master: Gate + MMIO host side
//   slave : ledger side
interface boreal_ledger_ring_if #(
    parameter int ENTRY_W = 256
);
    logic               wr_valid;
    logic               wr_ready;
    logic [ENTRY_W-1:0] wr_data;
    logic [31:0]        idx;
    logic               full;
    logic               sel;
    logic               wr;
    logic [31:0]        addr;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               ack;

    modport master (
        output wr_valid, wr_data, sel, wr, addr, wdata,
        input  wr_ready, idx, full, rdata, ack
    );

    modport slave (
        input  wr_valid, wr_data, sel, wr, addr, wdata,
        output wr_ready, idx, full, rdata, ack
    );

endinterface

// File: rtl/boreal_ledger_mem.sv
// 1W1R synchronous RAM, DEPTH x ENTRY_W, read-first (a read and write to the
// same address on one edge returns the old contents). The array has no reset.
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i         : read request, data on rdata_o after the edge
module boreal_ledger_mem #(
    parameter int ENTRY_W   = 256,
    parameter int DEPTH     = 1024,
    parameter int DEPTH_LOG = 10
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [DEPTH_LOG-1:0] waddr_i,
    input  logic [ENTRY_W-1:0]   wdata_i,
    input  logic                 re_i,
    input  logic [DEPTH_LOG-1:0] raddr_i,
    output logic [ENTRY_W-1:0]   rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/boreal_ledger_ring.sv
// Append-only ledger ring. Gate commits land at wp = idx mod DEPTH; stop or
// wrap policy on full; permanent seal; MMIO register file with a multi-cycle
// acknowledged read of any 32-bit word of any entry.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of boreal_ledger_ring_if (commit + MMIO)
module boreal_ledger_ring
    import boreal_ledger_pkg::*;
#(
    parameter int ENTRY_W   = 256,
    parameter int DEPTH     = 1024,
    parameter int DEPTH_LOG = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    boreal_ledger_ring_if.slave   bus
);

    localparam int WORDS = ENTRY_W / 32;
    localparam logic [DEPTH_LOG:0] COUNT_MAX = (DEPTH_LOG+1)'(DEPTH);

    mmio_state_e          state_q, state_d;
    logic [31:0]          idx_q, idx_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic                 wrap_en_q, wrap_en_d;
    logic                 sealed_q, sealed_d;
    logic                 overflow_q, overflow_d;
    logic                 wrapped_q, wrapped_d;
    logic [DEPTH_LOG-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]           rd_word_q, rd_word_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 ack_q;
    // Holds wr_ready low while in reset and for the first edge after release.
    logic                 live_q;

    logic                 full, accept, ovf_set, wrap_set;
    logic                 reg_acc, mem_rd;
    logic                 wr_ctrl, wr_status;
    logic [7:0]           off;
    logic [31:0]          reg_rval, word_sel;
    logic [ENTRY_W-1:0]   mem_rdata;
    logic                 unused_bits;

    assign off         = bus.addr[7:0];
    assign unused_bits = ^{bus.addr[31:8], bus.wdata[31:8]};

    assign full         = (count_q == COUNT_MAX);
    assign bus.wr_ready = live_q && !sealed_q && (wrap_en_q || !full);
    assign accept       = bus.wr_valid && bus.wr_ready;
    assign ovf_set      = live_q && bus.wr_valid && !bus.wr_ready && !sealed_q;
    assign wrap_set     = accept && full;

    assign bus.idx   = idx_q;
    assign bus.full  = full;
    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;

    boreal_ledger_mem #(
        .ENTRY_W  (ENTRY_W),
        .DEPTH    (DEPTH),
        .DEPTH_LOG(DEPTH_LOG)
    ) u_mem (
        .clk    (clk),
        .we_i   (accept),
        .waddr_i(idx_q[DEPTH_LOG-1:0]),
        .wdata_i(bus.wr_data),
        .re_i   (mem_rd),
        .raddr_i(rd_addr_q),
        .rdata_o(mem_rdata)
    );

    // MMIO FSM
    always_comb begin
        state_d = state_q;
        reg_acc = 1'b0;
        mem_rd  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.sel) begin
                    if (!bus.wr && off == OFF_RD_DATA) begin
                        mem_rd  = 1'b1;
                        state_d = ST_MEM;
                    end else begin
                        reg_acc = 1'b1;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_MEM:  state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        reg_rval = '0;
        unique case (off)
            OFF_IDX:     reg_rval = idx_q;
            OFF_DEPTH:   reg_rval = 32'(DEPTH);
            OFF_CTRL: begin
                reg_rval[CTRL_WRAP_EN] = wrap_en_q;
                reg_rval[CTRL_SEAL]    = sealed_q;
            end
            OFF_STATUS: begin
                reg_rval[STAT_FULL]     = full;
                reg_rval[STAT_OVERFLOW] = overflow_q;
                reg_rval[STAT_SEALED]   = sealed_q;
                reg_rval[STAT_WRAPPED]  = wrapped_q;
            end
            OFF_RD_ADDR: reg_rval[DEPTH_LOG-1:0] = rd_addr_q;
            OFF_RD_WORD: reg_rval[7:0]           = rd_word_q;
            OFF_COUNT:   reg_rval[DEPTH_LOG:0]   = count_q;
            default:     reg_rval = '0;
        endcase
    end

    // Out-of-range RD_WORD falls through to 0.
    always_comb begin
        word_sel = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (rd_word_q == 8'(w)) begin
                word_sel = mem_rdata[w*32 +: 32];
            end
        end
    end

    always_comb begin
        wr_ctrl    = reg_acc && bus.wr && off == OFF_CTRL;
        wr_status  = reg_acc && bus.wr && off == OFF_STATUS;

        idx_d      = accept ? idx_q + 32'd1 : idx_q;
        count_d    = (accept && !full) ? count_q + 1'b1 : count_q;
        wrap_en_d  = wrap_en_q;
        sealed_d   = sealed_q;
        rd_addr_d  = rd_addr_q;
        rd_word_d  = rd_word_q;
        rdata_d    = rdata_q;

        // Commit decisions above use the pre-write CTRL values.
        if (wr_ctrl) begin
            wrap_en_d = bus.wdata[CTRL_WRAP_EN];
            sealed_d  = sealed_q | bus.wdata[CTRL_SEAL];
        end
        // W1C; a set event on the same edge wins.
        overflow_d = (overflow_q && !(wr_status && bus.wdata[STAT_OVERFLOW])) || ovf_set;
        wrapped_d  = (wrapped_q && !(wr_status && bus.wdata[STAT_WRAPPED])) || wrap_set;

        if (reg_acc && bus.wr && off == OFF_RD_ADDR) rd_addr_d = bus.wdata[DEPTH_LOG-1:0];
        if (reg_acc && bus.wr && off == OFF_RD_WORD) rd_word_d = bus.wdata[7:0];

        if (reg_acc && !bus.wr) begin
            rdata_d = reg_rval;
        end else if (state_q == ST_MEM) begin
            rdata_d = word_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            count_q    <= '0;
            wrap_en_q  <= 1'b0;
            sealed_q   <= 1'b0;
            overflow_q <= 1'b0;
            wrapped_q  <= 1'b0;
            rd_addr_q  <= '0;
            rd_word_q  <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            wrap_en_q  <= wrap_en_d;
            sealed_q   <= sealed_d;
            overflow_q <= overflow_d;
            wrapped_q  <= wrapped_d;
            rd_addr_q  <= rd_addr_d;
            rd_word_q  <= rd_word_d;
            rdata_q    <= rdata_d;
            ack_q      <= (state_d == ST_ACK);
            live_q     <= 1'b1;
        end
    end

endmodule
